// File: rtl/breakout_pkg.sv
// Shared types and helpers for the breakout game-flow controller.
// State encoding matches the 2-bit state output seen by the display pipeline.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // One BCD digit step: returns {carry_out, digit}; a 9 with carry-in rolls to 0.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    if (!cin)
      return {1'b0, d};
    else if (d == BCD_MAX)
      return {1'b1, 4'd0};
    else
      return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Multi-digit packed BCD counter: ripple-carry increment, saturates at all-9s.
// clr has priority over inc; reset clears to zero.
module bcd_sat_counter
  import breakout_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   q
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d, inc_v;
  logic         carry;

  always_comb begin
    carry = inc;
    inc_v = q_q;
    for (int i = 0; i < DIGITS; i++) begin
      {carry, inc_v[4*i +: 4]} = bcd_digit_inc(q_q[4*i +: 4], carry);
    end
    q_d = q_q;
    // A carry out of the top digit means every digit was 9: hold instead of wrapping.
    if (clr)
      q_d = '0;
    else if (!carry)
      q_d = inc_v;
  end

  always_ff @(posedge clk) begin
    if (reset)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game-flow controller: NEWGAME/PLAY/NEWBALL/OVER FSM, lives, BCD score with
// high-score latch, and a frame-counted wait timer between balls and games.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 4,
  parameter int SCORE_DIGITS = 2,
  parameter int TIMER_FRAMES = 120
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      start_btn,
  input  logic                      hit,
  input  logic                      miss,
  output logic [1:0]                state,
  output logic                      gra_still,
  output logic                      new_ball,
  output logic [LIVES_W-1:0]        lives,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score,
  output logic                      timer_up
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam int TW = $clog2(TIMER_FRAMES + 1);

  state_e            state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SW-1:0]     hi_q, hi_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              new_ball_q, new_ball_d;
  logic              timer_load, score_clr, score_inc;
  logic [SW-1:0]     score_hit;
  logic              hit_carry;

  bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (score)
  );

  // Score as it will be after this cycle's hit, so a game-ending miss that
  // coincides with a hit still credits that point to the high score.
  always_comb begin
    hit_carry = hit;
    score_hit = score;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      {hit_carry, score_hit[4*i +: 4]} = bcd_digit_inc(score[4*i +: 4], hit_carry);
    end
    if (hit_carry)
      score_hit = score;
  end

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    hi_d       = hi_q;
    new_ball_d = 1'b0;
    timer_load = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        if (start_btn) begin
          state_d    = ST_PLAY;
          new_ball_d = 1'b1;
          score_clr  = 1'b1;
        end
      end
      ST_PLAY: begin
        score_inc = hit;
        if (miss) begin
          timer_load = 1'b1;
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = ST_NEWBALL;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
            if (score_hit > hi_q)
              hi_d = score_hit;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_up && start_btn) begin
          state_d    = ST_PLAY;
          new_ball_d = 1'b1;
        end
      end
      ST_OVER: begin
        if (timer_up) begin
          state_d = ST_NEWGAME;
          lives_d = LIVES_W'(LIVES);
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (timer_load)
      timer_d = TW'(TIMER_FRAMES);
    else if (frame_tick && timer_q != '0)
      timer_d = timer_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_NEWGAME;
      lives_q    <= LIVES_W'(LIVES);
      hi_q       <= '0;
      timer_q    <= '0;
      new_ball_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      hi_q       <= hi_d;
      timer_q    <= timer_d;
      new_ball_q <= new_ball_d;
    end
  end

  assign state     = state_q;
  assign gra_still = (state_q != ST_PLAY);
  assign new_ball  = new_ball_q;
  assign lives     = lives_q;
  assign hi_score  = hi_q;
  assign timer_up  = (timer_q == '0);

endmodule
